// File: rtl/encoder_pkg.sv
// Shared constants and the position step rule for the encoder_bank peripheral.
// Build option ENCODER_ACCEL_EN enables velocity scaling (see encoder_bank.sv).
package encoder_pkg;

  localparam logic FIELD_VALUE  = 1'b0;
  localparam logic FIELD_CONFIG = 1'b1;

  function automatic int wrap_bit(input int width);
    return width - 1;
  endfunction

  // Operands are zero-extended to 33 bits; with limit < 2^(WIDTH-1) this equals WIDTH+1-bit math.
  function automatic logic [32:0] step(input logic [32:0] value,
                                       input logic [32:0] velocity,
                                       input logic [32:0] limit,
                                       input logic        up,
                                       input logic        wrap);
    logic [32:0] sum;
    sum = value + velocity;
    if (up) begin
      if (sum > limit) return wrap ? (sum - limit - 33'd1) : limit;
      return sum;
    end
    if (velocity > value) return wrap ? (limit + 33'd1 - (velocity - value)) : '0;
    return value - velocity;
  endfunction

endpackage

// File: rtl/encoder_channel.sv
// One encoder channel: pin debouncers, quadrature decode, optional velocity
// (ENCODER_ACCEL_EN) and the value/limit/wrap/changed registers.
module encoder_channel
  import encoder_pkg::*;
#(
  parameter int WIDTH          = 16,
  parameter int DEBOUNCE_WIDTH = 11
`ifdef ENCODER_ACCEL_EN
  , parameter int VELOCITY_SHIFT = 3
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
`ifdef ENCODER_ACCEL_EN
  input  logic             tick,
`endif
  input  logic             wr_value,
  input  logic             wr_config,
  input  logic             clr_changed,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] value,
  output logic [WIDTH-1:0] cfg,
  output logic             changed
);

  localparam int WB = wrap_bit(WIDTH);
  localparam int VW = WIDTH + 1;

  logic [1:0]                pins, sync1, sync2, stable, prev;
  logic [DEBOUNCE_WIDTH-1:0] dcnt [2];
  logic                      cnt, dir, take;
  logic [WIDTH-2:0]          limit;
  logic                      wrap;
  logic [VW-1:0]             velocity;
  logic [WIDTH-1:0]          step_val;

  assign pins = {b, a};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1  <= '0;
      sync2  <= '0;
      stable <= '0;
      prev   <= '0;
      for (int unsigned i = 0; i < 2; i++) dcnt[i] <= '0;
    end else begin
      sync1 <= pins;
      sync2 <= sync1;
      prev  <= stable;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] == stable[i]) dcnt[i] <= '0;
        else if (dcnt[i] == '1) begin
          stable[i] <= sync2[i];
          dcnt[i]   <= '0;
        end else dcnt[i] <= dcnt[i] + 1'b1;
      end
    end
  end

  assign cnt = |(stable ^ prev);
  assign dir = stable[0] ^ prev[1];

`ifdef ENCODER_ACCEL_EN
  logic [WIDTH-1:0] pulse_cnt;
  logic [VW-1:0]    scaled, lim1, vel_next;

  always_comb begin
    scaled   = ({1'b0, pulse_cnt} << VELOCITY_SHIFT) + 1'b1;
    lim1     = {2'b00, limit} + 1'b1;
    vel_next = (scaled < lim1) ? scaled : lim1;
  end

  // A count landing on the sampling tick is dropped with the reset of pulse_cnt.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pulse_cnt <= '0;
      velocity  <= VW'(1);
    end else if (tick) begin
      pulse_cnt <= '0;
      velocity  <= vel_next;
    end else if (cnt && pulse_cnt != '1) begin
      pulse_cnt <= pulse_cnt + 1'b1;
    end
  end
`else
  assign velocity = VW'(1);
`endif

  assign step_val = WIDTH'(step(33'(value), 33'(velocity), 33'(limit), dir, wrap));
  assign take     = cnt && !wr_value && !wr_config;
  assign cfg      = {wrap, limit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value   <= '0;
      limit   <= '1;
      wrap    <= 1'b0;
      changed <= 1'b0;
    end else begin
      if (wr_value) begin
        value <= (wdata > {1'b0, limit}) ? {1'b0, limit} : wdata;
      end else if (wr_config) begin
        limit <= wdata[WIDTH-2:0];
        wrap  <= wdata[WB];
        if (value > {1'b0, wdata[WIDTH-2:0]}) value <= {1'b0, wdata[WIDTH-2:0]};
      end else if (take) begin
        value <= step_val;
      end
      changed <= (take && step_val != value) | (changed & ~clr_changed);
    end
  end

endmodule

// File: rtl/encoder_bank.sv
// Multi-channel rotary encoder peripheral with register bus access.
// Define ENCODER_ACCEL_EN to add the shared velocity timer and step scaling.
module encoder_bank
  import encoder_pkg::*;
#(
  parameter  int CHANNELS       = 4,
  parameter  int WIDTH          = 16,
  parameter  int DEBOUNCE_WIDTH = 11,
  parameter  int TIMER_WIDTH    = 20,
  parameter  int VELOCITY_SHIFT = 3,
  localparam int CH_BITS        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [CH_BITS:0]    reg_addr,
  input  logic                reg_we,
  input  logic [WIDTH-1:0]    reg_data,
  output logic [WIDTH-1:0]    reg_q,
  input  logic [CHANNELS-1:0] a,
  input  logic [CHANNELS-1:0] b,
  output logic [CHANNELS-1:0] changed
);

  if (CHANNELS < 1 || CHANNELS > 16 || WIDTH < 8 || WIDTH > 32 ||
      DEBOUNCE_WIDTH < 1 || TIMER_WIDTH < 1 || VELOCITY_SHIFT < 0) begin : g_bad_params
    $error("encoder_bank: parameter out of range");
  end

  logic [1:0]          rst_sync;
  logic                rst_n_i;
  logic [CH_BITS-1:0]  sel_ch;
  logic                sel_fld;
  logic [CHANNELS-1:0] wr_value, wr_config, clr_changed;
  logic [WIDTH-1:0]    ch_value [CHANNELS];
  logic [WIDTH-1:0]    ch_cfg   [CHANNELS];
  logic [WIDTH-1:0]    rd_mux;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= '0;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end
  assign rst_n_i = rst_sync[1];

  assign sel_ch  = reg_addr[CH_BITS:1];
  assign sel_fld = reg_addr[0];

  // Unmatched (out-of-range) channel numbers leave every strobe low and read as zero.
  always_comb begin
    wr_value    = '0;
    wr_config   = '0;
    clr_changed = '0;
    rd_mux      = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (sel_ch == CH_BITS'(i)) begin
        wr_value[i]    = reg_we && sel_fld == FIELD_VALUE;
        wr_config[i]   = reg_we && sel_fld == FIELD_CONFIG;
        clr_changed[i] = !reg_we && sel_fld == FIELD_VALUE;
        rd_mux         = (sel_fld == FIELD_CONFIG) ? ch_cfg[i] : ch_value[i];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) reg_q <= '0;
    else          reg_q <= rd_mux;
  end

`ifdef ENCODER_ACCEL_EN
  logic [TIMER_WIDTH-1:0] timer;
  logic                   tick;

  always_ff @(posedge clk or negedge rst_n_i) begin
    if (!rst_n_i) timer <= '0;
    else          timer <= timer + 1'b1;
  end
  assign tick = &timer;
`endif

  for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
    encoder_channel #(
      .WIDTH          (WIDTH),
      .DEBOUNCE_WIDTH (DEBOUNCE_WIDTH)
`ifdef ENCODER_ACCEL_EN
      , .VELOCITY_SHIFT (VELOCITY_SHIFT)
`endif
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n_i),
      .a           (a[n]),
      .b           (b[n]),
`ifdef ENCODER_ACCEL_EN
      .tick        (tick),
`endif
      .wr_value    (wr_value[n]),
      .wr_config   (wr_config[n]),
      .clr_changed (clr_changed[n]),
      .wdata       (reg_data),
      .value       (ch_value[n]),
      .cfg         (ch_cfg[n]),
      .changed     (changed[n])
    );
  end

endmodule

// File: tb/tb_encoder_bank.sv
// Scoreboard bench for encoder_bank (default build, velocity fixed at 1).
module tb_encoder_bank;

  localparam int CHANNELS = 5;
  localparam int WIDTH    = 16;
  localparam int DEB      = 11;
  localparam int CH_BITS  = 3;
  localparam int HOLD     = (1 << DEB) + 64;
  localparam logic [CH_BITS:0] IDLE_ADDR = 4'd1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [CH_BITS:0]    reg_addr;
  logic                reg_we;
  logic [WIDTH-1:0]    reg_data;
  logic [WIDTH-1:0]    reg_q;
  logic [CHANNELS-1:0] a, b, changed;

  encoder_bank #(
    .CHANNELS       (CHANNELS),
    .WIDTH          (WIDTH),
    .DEBOUNCE_WIDTH (DEB),
    .TIMER_WIDTH    (20),
    .VELOCITY_SHIFT (3)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .reg_addr (reg_addr),
    .reg_we   (reg_we),
    .reg_data (reg_data),
    .reg_q    (reg_q),
    .a        (a),
    .b        (b),
    .changed  (changed)
  );

  always #5 clk = ~clk;

  typedef struct {
    string               name;
    logic [WIDTH-1:0]    q;
    logic [CHANNELS-1:0] chg;
  } exp_t;

  exp_t sbq[$];
  exp_t mon_e;
  int   checks = 0;
  int   failures = 0;
  logic rd_issue = 1'b0;
  logic rd_d = 1'b0;

  int            m_value [CHANNELS];
  int            m_limit [CHANNELS];
  bit            m_wrap  [CHANNELS];
  bit [CHANNELS-1:0] m_chg;
  bit            pa [CHANNELS];
  bit            pb [CHANNELS];

  always @(posedge clk) rd_d <= rd_issue;

  always @(negedge clk) begin
    if (rd_d) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL scoreboard_underflow: got empty queue, required a pending entry");
      end else begin
        mon_e = sbq.pop_front();
        checks++;
        if (reg_q !== mon_e.q) begin
          failures++;
          $display("FAIL %s reg_q: got %h required %h", mon_e.name, reg_q, mon_e.q);
        end
        checks++;
        if (changed !== mon_e.chg) begin
          failures++;
          $display("FAIL %s changed: got %b required %b", mon_e.name, changed, mon_e.chg);
        end
      end
    end
  end

  function automatic void model_reset();
    for (int i = 0; i < CHANNELS; i++) begin
      m_value[i] = 0;
      m_limit[i] = 'h7FFF;
      m_wrap[i]  = 1'b0;
      pa[i]      = 1'b0;
      pb[i]      = 1'b0;
    end
    m_chg = '0;
  endfunction

  function automatic void model_count(input int ch, input bit up);
    int v, nv, lim;
    v   = m_value[ch];
    lim = m_limit[ch];
    if (up) nv = (v + 1 > lim) ? (m_wrap[ch] ? v + 1 - lim - 1 : lim) : v + 1;
    else    nv = (1 > v) ? (m_wrap[ch] ? lim + 1 - (1 - v) : 0) : v - 1;
    if (nv != v) m_chg[ch] = 1'b1;
    m_value[ch] = nv;
  endfunction

  task automatic toggle(input int ch, input bit up, input bit count);
    bit old_b, dir;
    old_b = pb[ch];
    if (up ? (pa[ch] == pb[ch]) : (pa[ch] != pb[ch])) pa[ch] = !pa[ch];
    else pb[ch] = !pb[ch];
    dir   = pa[ch] ^ old_b;
    a[ch] = pa[ch];
    b[ch] = pb[ch];
    if (count) model_count(ch, dir);
  endtask

  task automatic settle();
    repeat (HOLD) @(negedge clk);
  endtask

  task automatic do_write(input int ch, input int fld, input int data);
    reg_addr = {CH_BITS'(ch), fld[0]};
    reg_data = WIDTH'(data);
    reg_we   = 1'b1;
    if (ch < CHANNELS) begin
      if (fld == 0) begin
        m_value[ch] = (data > m_limit[ch]) ? m_limit[ch] : data;
      end else begin
        m_limit[ch] = data & 'h7FFF;
        m_wrap[ch]  = data[15];
        if (m_value[ch] > m_limit[ch]) m_value[ch] = m_limit[ch];
      end
    end
    @(negedge clk);
    reg_we   = 1'b0;
    reg_addr = IDLE_ADDR;
  endtask

  task automatic do_read(input int ch, input int fld, input string name);
    exp_t e;
    e.name = name;
    if (ch >= CHANNELS) e.q = '0;
    else if (fld == 0) begin
      e.q = WIDTH'(m_value[ch]);
      m_chg[ch] = 1'b0;
    end else e.q = {m_wrap[ch], 15'(m_limit[ch])};
    e.chg = m_chg;
    sbq.push_back(e);
    reg_addr = {CH_BITS'(ch), fld[0]};
    reg_we   = 1'b0;
    rd_issue = 1'b1;
    @(negedge clk);
    rd_issue = 1'b0;
    reg_addr = IDLE_ADDR;
  endtask

  task automatic read_all(input string name);
    for (int ch = 0; ch < CHANNELS; ch++) begin
      do_read(ch, 1, name);
      do_read(ch, 0, name);
    end
  endtask

  initial begin
    #900_000;
    $display("FAIL watchdog: got no completion, required finish before time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    a        = '0;
    b        = '0;
    reg_we   = 1'b0;
    reg_addr = IDLE_ADDR;
    reg_data = '0;
    model_reset();
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    read_all("reset");

    repeat (4) begin
      toggle(0, 1'b1, 1'b1);
      settle();
    end
    do_read(0, 1, "detent_changed");
    do_read(0, 0, "detent_value");
    do_read(0, 1, "detent_cleared");

    do_write(1, 1, 'h800A);
    do_write(1, 0, 9);
    do_read(1, 0, "read_after_write");
    repeat (3) begin
      toggle(1, 1'b1, 1'b1);
      settle();
      do_read(1, 0, "wrap_up");
    end
    do_write(1, 1, 'h000A);
    do_write(1, 0, 9);
    repeat (3) begin
      toggle(1, 1'b1, 1'b1);
      settle();
      do_read(1, 1, "sat_up_changed");
      do_read(1, 0, "sat_up");
    end

    do_write(2, 0, 2);
    repeat (5) begin
      toggle(2, 1'b0, 1'b1);
      settle();
      do_read(2, 1, "sat_down_changed");
      do_read(2, 0, "sat_down");
    end

    // Value write held across the whole debounce window so it overlaps the count.
    reg_addr = {CH_BITS'(3), 1'b0};
    reg_data = 16'd7;
    reg_we   = 1'b1;
    toggle(3, 1'b1, 1'b0);
    m_value[3] = 7;
    settle();
    reg_we   = 1'b0;
    reg_addr = IDLE_ADDR;
    do_read(3, 1, "collide_changed");
    do_read(3, 0, "collide_value");

    do_write(3, 0, 9);
    do_write(3, 1, 5);
    do_read(3, 1, "limit_clamp_changed");
    do_read(3, 0, "limit_clamp_value");
    do_write(3, 0, 'h1234);
    do_read(3, 0, "value_above_limit");

    do_write(6, 0, 'h0055);
    do_write(5, 1, 'h8003);
    do_read(6, 0, "oor_value");
    do_read(5, 1, "oor_config");
    do_read(7, 1, "oor_config7");
    read_all("after_oor");

    for (int r = 0; r < 10; r++) begin
      for (int ch = 0; ch < CHANNELS; ch++) begin
        if ($urandom % 4 == 0)
          do_write(ch, 1, (($urandom % 2) << 15) | int'($urandom_range(0, 20)));
        if ($urandom % 3 == 0)
          do_write(ch, 0, int'($urandom_range(0, 25)));
      end
      for (int ch = 0; ch < CHANNELS; ch++) begin
        case ($urandom % 3)
          1: toggle(ch, 1'b1, 1'b1);
          2: toggle(ch, 1'b0, 1'b1);
          default: ;
        endcase
      end
      settle();
      read_all("random");
    end

    toggle(0, 1'b1, 1'b0);
    repeat (1000) @(negedge clk);
    rst_n = 1'b0;
    a     = '0;
    b     = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    settle();
    read_all("mid_debounce_reset");

    repeat (3) @(negedge clk);
    checks++;
    if (sbq.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
